// File: rtl/reg_op_sequencer_if.sv
// Command, register-file and status signals between a host and reg_op_sequencer.
// The sequencer uses the slave modport; the host side uses master.
interface reg_op_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_rs;
  logic [DATA_W-1:0] cmd_imm;
  logic [ADDR_W-1:0] ReadRegA;
  logic [ADDR_W-1:0] ReadRegB;
  logic [DATA_W-1:0] ReadDataA;
  logic [DATA_W-1:0] ReadDataB;
  logic              WriteEnable;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              done;
  logic              flag_z;
  logic              flag_c;

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, ReadDataA, ReadDataB,
    output cmd_ready, ReadRegA, ReadRegB, WriteEnable, WriteReg, WriteData, done,
           flag_z, flag_c
  );

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, ReadDataA, ReadDataB,
    input  cmd_ready, ReadRegA, ReadRegB, WriteEnable, WriteReg, WriteData, done,
           flag_z, flag_c
  );
endinterface

// File: rtl/reg_op_sequencer.sv
// Three-state (idle/fetch/write-back) sequencer for LDI/MOV/ADD/SUB on an external register file.
// Define REG_OP_SEQUENCER_FLAGS_EN to build the zero and carry/borrow flag logic.
module reg_op_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 2
) (
  input logic               clk,
  input logic               reset,
  reg_op_sequencer_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StFetch, StWb} state_e;

  localparam logic [1:0] OpLdi = 2'b00;
  localparam logic [1:0] OpMov = 2'b01;
  localparam logic [1:0] OpAdd = 2'b10;

  state_e            state_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] sum_add;
  logic [DATA_W-1:0] diff_sub;
  logic [DATA_W-1:0] result;

  // Ready is decoded from state so it rises in the first cycle after reset drops.
  assign bus.cmd_ready = (state_q == StIdle) && !reset;

`ifdef REG_OP_SEQUENCER_FLAGS_EN
  logic carry_add;
  logic borrow_sub;
  logic carry_d;
  logic flag_z_q;
  logic flag_c_q;

  assign {carry_add, sum_add}   = {1'b0, bus.ReadDataA} + {1'b0, bus.ReadDataB};
  // Top bit of the widened difference is set exactly when A < B.
  assign {borrow_sub, diff_sub} = {1'b0, bus.ReadDataA} - {1'b0, bus.ReadDataB};
  assign bus.flag_z = flag_z_q;
  assign bus.flag_c = flag_c_q;

  always_comb begin
    carry_d = 1'b0;
    if (op_q == OpAdd) begin
      carry_d = carry_add;
    end else if (op_q != OpLdi && op_q != OpMov) begin
      carry_d = borrow_sub;
    end
  end
`else
  assign sum_add    = bus.ReadDataA + bus.ReadDataB;
  assign diff_sub   = bus.ReadDataA - bus.ReadDataB;
  assign bus.flag_z = 1'b0;
  assign bus.flag_c = 1'b0;
`endif

  always_comb begin
    result = imm_q;
    case (op_q)
      OpLdi:   result = imm_q;
      OpMov:   result = bus.ReadDataB;
      OpAdd:   result = sum_add;
      default: result = diff_sub;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      op_q            <= '0;
      rd_q            <= '0;
      imm_q           <= '0;
      bus.ReadRegA    <= '0;
      bus.ReadRegB    <= '0;
      bus.WriteEnable <= 1'b0;
      bus.WriteReg    <= '0;
      bus.WriteData   <= '0;
      bus.done        <= 1'b0;
`ifdef REG_OP_SEQUENCER_FLAGS_EN
      flag_z_q        <= 1'b0;
      flag_c_q        <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          bus.WriteEnable <= 1'b0;
          bus.done        <= 1'b0;
          if (bus.cmd_valid) begin
            op_q         <= bus.cmd_op;
            rd_q         <= bus.cmd_rd;
            imm_q        <= bus.cmd_imm;
            bus.ReadRegA <= bus.cmd_rd;
            bus.ReadRegB <= bus.cmd_rs;
            state_q      <= StFetch;
          end
        end
        StFetch: begin
          bus.WriteEnable <= 1'b1;
          bus.done        <= 1'b1;
          bus.WriteReg    <= rd_q;
          bus.WriteData   <= result;
`ifdef REG_OP_SEQUENCER_FLAGS_EN
          flag_z_q        <= (result == '0);
          flag_c_q        <= carry_d;
`endif
          state_q         <= StWb;
        end
        StWb: begin
          bus.WriteEnable <= 1'b0;
          bus.done        <= 1'b0;
          state_q         <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_op_sequencer.sv
// Self-checking bench for reg_op_sequencer: bench-owned register file plus an arithmetic
// reference model; flag expectations follow REG_OP_SEQUENCER_FLAGS_EN.
module tb_reg_op_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  reg_op_sequencer_if #(.DATA_W(8), .ADDR_W(2)) bus ();

  reg_op_sequencer #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] rf [4];
  logic       preload_req = 1'b0;
  int         m [4];
`ifdef REG_OP_SEQUENCER_FLAGS_EN
  localparam bit FlagsOn = 1'b1;
`else
  localparam bit FlagsOn = 1'b0;
`endif

  assign bus.ReadDataA = rf[bus.ReadRegA];
  assign bus.ReadDataB = rf[bus.ReadRegB];

  always @(posedge clk) begin
    if (preload_req) begin
      rf[0] <= 8'h00; rf[1] <= 8'h02; rf[2] <= 8'h03; rf[3] <= 8'h04;
    end else if (bus.WriteEnable) begin
      rf[bus.WriteReg] <= bus.WriteData;
    end
  end

  // Returns result in bits [7:0] and carry/borrow in bit 8.
  function automatic int ref_op(input int op, input int a, input int b, input int imm);
    int r;
    int c;
    c = 0;
    case (op)
      0: r = imm;
      1: r = b;
      2: begin r = a + b; c = (r > 255) ? 1 : 0; end
      default: begin r = a - b; c = (r < 0) ? 1 : 0; end
    endcase
    if (r < 0) r += 256;
    r = r % 256;
    return r + c * 256;
  endfunction

  task automatic preload();
    preload_req = 1'b1;
    @(posedge clk); #1;
    preload_req = 1'b0;
    m[0] = 0; m[1] = 2; m[2] = 3; m[3] = 4;
  endtask

  task automatic noise();
    bus.cmd_op  = 2'($urandom);
    bus.cmd_rd  = 2'($urandom);
    bus.cmd_rs  = 2'($urandom);
    bus.cmd_imm = 8'($urandom);
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0;
    noise();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", bus.cmd_ready); end
    total++; if (bus.WriteEnable !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL rst_we_done got=%b%b want=00", bus.WriteEnable, bus.done); end
    total++; if (bus.WriteReg !== 2'd0 || bus.WriteData !== 8'd0) begin bad++; $display("FAIL rst_wr got=%0d/%h want=0/00", bus.WriteReg, bus.WriteData); end
    total++; if (bus.ReadRegA !== 2'd0 || bus.ReadRegB !== 2'd0) begin bad++; $display("FAIL rst_rd got=%0d/%0d want=0/0", bus.ReadRegA, bus.ReadRegB); end
    total++; if (bus.flag_z !== 1'b0 || bus.flag_c !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b want=00", bus.flag_z, bus.flag_c); end
    reset = 1'b0;
    #1;
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", bus.cmd_ready); end
    @(posedge clk); #1;
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b want=1", bus.cmd_ready); end
  endtask

  task automatic do_cmd(input int op, input int rd, input int rs, input int imm);
    int n;
    int e;
    int res;
    int z;
    int c;
    e   = ref_op(op, m[rd], m[rs], imm);
    res = e % 256;
    c   = FlagsOn ? e / 256 : 0;
    z   = FlagsOn ? ((res == 0) ? 1 : 0) : 0;
    bus.cmd_op = 2'(op); bus.cmd_rd = 2'(rd); bus.cmd_rs = 2'(rs); bus.cmd_imm = 8'(imm);
    bus.cmd_valid = 1'b1;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    total++;
    if (bus.cmd_ready !== 1'b1) begin
      bad++; $display("FAIL cmd_ready_timeout got=%b want=1", bus.cmd_ready);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    noise();
    total++; if (bus.WriteEnable !== 1'b0 || bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL fetch_state we=%b ready=%b want=0 0", bus.WriteEnable, bus.cmd_ready); end
    total++; if (bus.ReadRegA !== 2'(rd) || bus.ReadRegB !== 2'(rs)) begin bad++; $display("FAIL fetch_addr got=%0d/%0d want=%0d/%0d", bus.ReadRegA, bus.ReadRegB, rd, rs); end
    @(posedge clk); #1;
    m[rd] = res;
    total++; if (bus.WriteEnable !== 1'b1 || bus.done !== 1'b1) begin bad++; $display("FAIL wb_pulse we=%b done=%b want=1 1", bus.WriteEnable, bus.done); end
    total++; if (bus.WriteReg !== 2'(rd) || bus.WriteData !== 8'(res)) begin bad++; $display("FAIL wb_data op=%0d got=%0d/%h want=%0d/%h", op, bus.WriteReg, bus.WriteData, rd, res); end
    total++; if (bus.flag_z !== 1'(z) || bus.flag_c !== 1'(c)) begin bad++; $display("FAIL wb_flags op=%0d got=z%b c%b want=z%0d c%0d", op, bus.flag_z, bus.flag_c, z, c); end
    @(posedge clk); #1;
    total++; if (bus.WriteEnable !== 1'b0 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL after_wb we=%b done=%b ready=%b want=0 0 1", bus.WriteEnable, bus.done, bus.cmd_ready); end
    total++; if (bus.WriteData !== 8'(res) || rf[rd] !== 8'(res)) begin bad++; $display("FAIL hold_data got=%h rf=%h want=%h", bus.WriteData, rf[rd], res); end
  endtask

  task automatic test_directed();
    preload(); do_cmd(2, 1, 2, 0);                      // ADD R1,R2 -> 05
    preload(); do_cmd(0, 3, 0, 8'hFF); do_cmd(2, 3, 1, 0); // FF+02 -> 01 with carry
    total++; if (rf[3] !== 8'h01) begin bad++; $display("FAIL add_wrap got=%h want=01", rf[3]); end
    preload(); do_cmd(3, 0, 3, 0);                      // 00-04 -> FC with borrow
    total++; if (rf[0] !== 8'hFC) begin bad++; $display("FAIL sub_wrap got=%h want=fc", rf[0]); end
    do_cmd(3, 2, 2, 0);                                 // SUB R2,R2 -> 00
    total++; if (rf[2] !== 8'h00) begin bad++; $display("FAIL sub_self got=%h want=00", rf[2]); end
    do_cmd(1, 1, 0, 0);                                 // MOV R1,R0
  endtask

  task automatic test_random();
    preload();
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) begin noise(); @(posedge clk); #1; end
      do_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
    end
    for (int r = 0; r < 4; r++) begin
      total++; if (rf[r] !== 8'(m[r])) begin bad++; $display("FAIL rand_regs r%0d got=%h want=%h", r, rf[r], m[r]); end
    end
  endtask

  task automatic test_back_to_back();
    int ops [3] = '{2, 3, 1};
    int rds [3] = '{1, 0, 2};
    int rss [3] = '{2, 3, 1};
    int hs_cyc [3];
    int exp_q [$];
    int k;
    int we_cnt;
    bit hs;
    preload();
    k = 0; we_cnt = 0;
    bus.cmd_op = 2'(ops[0]); bus.cmd_rd = 2'(rds[0]); bus.cmd_rs = 2'(rss[0]); bus.cmd_imm = 8'h5A;
    bus.cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      hs = bus.cmd_valid && bus.cmd_ready;
      if (hs) begin
        exp_q.push_back(ref_op(ops[k], m[rds[k]], m[rss[k]], 0) % 256);
        m[rds[k]] = exp_q[$];
      end
      @(posedge clk); #1;
      if (bus.WriteEnable === 1'b1) begin
        we_cnt++;
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_extra_write got=%h want=none", bus.WriteData); end
        else begin
          if (bus.WriteData !== 8'(exp_q[0])) begin bad++; $display("FAIL b2b_data got=%h want=%h", bus.WriteData, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      if (hs) begin
        hs_cyc[k] = cyc;
        k++;
        if (k < 3) begin
          bus.cmd_op = 2'(ops[k]); bus.cmd_rd = 2'(rds[k]); bus.cmd_rs = 2'(rss[k]);
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
    end
    bus.cmd_valid = 1'b0;
    total++; if (k !== 3) begin bad++; $display("FAIL b2b_handshakes got=%0d want=3", k); end
    total++; if (we_cnt !== 3) begin bad++; $display("FAIL b2b_writes got=%0d want=3", we_cnt); end
    if (k == 3) begin
      total++; if (hs_cyc[1] - hs_cyc[0] != 3 || hs_cyc[2] - hs_cyc[1] != 3) begin bad++; $display("FAIL b2b_spacing got=%0d,%0d want=3,3", hs_cyc[1] - hs_cyc[0], hs_cyc[2] - hs_cyc[1]); end
    end
    for (int r = 0; r < 4; r++) begin
      total++; if (rf[r] !== 8'(m[r])) begin bad++; $display("FAIL b2b_regs r%0d got=%h want=%h", r, rf[r], m[r]); end
    end
  endtask

  task automatic test_reset_abort();
    int n;
    int we_seen;
    preload();
    bus.cmd_op = 2'd1; bus.cmd_rd = 2'd1; bus.cmd_rs = 2'd3; bus.cmd_imm = 8'h00;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 10) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.WriteEnable !== 1'b0 || bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL abort_in_reset we=%b ready=%b want=0 0", bus.WriteEnable, bus.cmd_ready); end
    reset = 1'b0;
    #1;
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", bus.cmd_ready); end
    we_seen = 0;
    repeat (4) begin @(posedge clk); #1; if (bus.WriteEnable === 1'b1) we_seen++; end
    total++; if (we_seen != 0) begin bad++; $display("FAIL abort_no_write got=%0d want=0", we_seen); end
    total++; if (rf[1] !== 8'h02) begin bad++; $display("FAIL abort_r1 got=%h want=02", rf[1]); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'd0; bus.cmd_rd = 2'd0; bus.cmd_rs = 2'd0; bus.cmd_imm = 8'd0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
